// File: rtl/halfband_interpolator_if.sv
// Sample/strobe bundle between the halfband interpolator and its neighbours in the FM transmit chain.
interface halfband_interpolator_if #(
    parameter int WIDTH = 16
);
    logic                    enable;
    logic signed [WIDTH-1:0] data_in;
    logic                    stb_in;
    logic                    req;
    logic signed [WIDTH-1:0] data_out;
    logic                    stb_out;
    logic                    busy;
    logic [2:0]              fifo_level;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output enable, data_in, stb_in, req,
        input  data_out, stb_out, busy, fifo_level, overflow, underflow
    );

    modport slave (
        input  enable, data_in, stb_in, req,
        output data_out, stb_out, busy, fifo_level, overflow, underflow
    );
endinterface

// File: rtl/halfband_interpolator.sv
// 11-tap halfband interpolate-by-2 FIR: serial symmetric MAC feeding a 4-deep output FIFO.
// Build option HB_INTERP_SAT_EN: clamp the filtered output y0 instead of wrapping it.
module halfband_interpolator #(
    parameter int WIDTH  = 16,
    parameter int COEF_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    halfband_interpolator_if.slave bus
);
    localparam int ACC_W = WIDTH + COEF_W + 3;
    // Interpolation gain of 2 is folded in: c0 + c2 + c4 = 0.5 in Q1.15, doubled by symmetry.
    localparam logic signed [COEF_W-1:0] C0  = COEF_W'(768);
    localparam logic signed [COEF_W-1:0] C2  = COEF_W'(-4096);
    localparam logic signed [COEF_W-1:0] C4  = COEF_W'(19712);
    localparam logic signed [ACC_W-1:0]  RND = ACC_W'(16384);

    typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, ROUND, PUSH1} state_t;
    state_t state_reg, state_next;

    logic                    clr;
    logic [5:0][WIDTH-1:0]   hist_reg, hist_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next, prod;
    logic [WIDTH-1:0]        pre_a, pre_b, y0, push_data;
    logic signed [WIDTH:0]   pre_sum;
    logic signed [COEF_W-1:0] coef;
    logic                    accept, push_en, pop;

    logic [WIDTH-1:0] fifo_mem [0:3];
    logic [1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [2:0]       level_reg;
    logic [WIDTH-1:0] data_out_reg;
    logic             stb_out_reg, overflow_reg, underflow_reg;

    assign clr = rst | ~bus.enable;
    assign pop = bus.req && (level_reg != 3'd0);

    assign hist_next[0] = accept ? bus.data_in : hist_reg[0];
    for (genvar gi = 1; gi < 6; gi++) begin : g_hist
        assign hist_next[gi] = accept ? hist_reg[gi-1] : hist_reg[gi];
    end

    // Symmetric tap pair and coefficient for the current MAC step.
    always_comb begin
        pre_a = hist_reg[0];
        pre_b = hist_reg[5];
        coef  = C0;
        case (state_reg)
            MAC1: begin
                pre_a = hist_reg[1];
                pre_b = hist_reg[4];
                coef  = C2;
            end
            MAC2: begin
                pre_a = hist_reg[2];
                pre_b = hist_reg[3];
                coef  = C4;
            end
            default: ;
        endcase
    end

    assign pre_sum = {pre_a[WIDTH-1], pre_a} + {pre_b[WIDTH-1], pre_b};
    assign prod    = ACC_W'(pre_sum) * ACC_W'(coef);

`ifdef HB_INTERP_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(2 ** (WIDTH - 1)));
    logic signed [ACC_W-1:0] rounded;
    assign rounded = (acc_reg + RND) >>> 15;
    assign y0 = (rounded > Y_MAX) ? Y_MAX[WIDTH-1:0] :
                (rounded < Y_MIN) ? Y_MIN[WIDTH-1:0] : rounded[WIDTH-1:0];
`else
    assign y0 = WIDTH'((acc_reg + RND) >>> 15);
`endif

    always_ff @(posedge clk) begin
        if (clr) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        accept     = 1'b0;
        push_en    = 1'b0;
        push_data  = y0;
        case (state_reg)
            IDLE: begin
                if (bus.stb_in && (level_reg <= 3'd2)) begin
                    accept     = 1'b1;
                    state_next = MAC0;
                end
            end
            MAC0: begin
                acc_next   = prod;
                state_next = MAC1;
            end
            MAC1: begin
                acc_next   = acc_reg + prod;
                state_next = MAC2;
            end
            MAC2: begin
                acc_next   = acc_reg + prod;
                state_next = ROUND;
            end
            ROUND: begin
                push_en    = 1'b1;
                state_next = PUSH1;
            end
            PUSH1: begin
                // Odd phase is the delayed centre tap, passed through untouched.
                push_en    = 1'b1;
                push_data  = hist_reg[2];
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_en) fifo_mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hist_reg      <= '0;
            acc_reg       <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            data_out_reg  <= '0;
            stb_out_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            hist_reg    <= hist_next;
            acc_reg     <= acc_next;
            stb_out_reg <= pop;
            if (push_en) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop) begin
                data_out_reg <= fifo_mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + 2'd1;
            end
            case ({push_en, pop})
                2'b10:   level_reg <= level_reg + 3'd1;
                2'b01:   level_reg <= level_reg - 3'd1;
                default: ;
            endcase
            if (bus.stb_in && !accept)            overflow_reg  <= 1'b1;
            if (bus.req && (level_reg == 3'd0))   underflow_reg <= 1'b1;
        end
    end

    assign bus.data_out   = data_out_reg;
    assign bus.stb_out    = stb_out_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.fifo_level = level_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.underflow  = underflow_reg;
endmodule

// File: tb/tb_halfband_interpolator.sv
// Scoreboard bench for halfband_interpolator: arithmetic reference model feeds an expected queue,
// an independent negedge monitor compares every stb_out against it.
module tb_halfband_interpolator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    halfband_interpolator_if #(.WIDTH(16)) bus ();
    halfband_interpolator #(.WIDTH(16), .COEF_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;
    int exp_q[$];
    int got_log[$];
    int mh[6];
    int n_out = 0;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int k = 0; k < 6; k++) mh[k] = 0;
    endtask

    // Reference: even output = rounded symmetric FIR sum, odd output = input delayed by two.
    task automatic model_push(input int x);
        longint acc;
        longint r;
        for (int k = 5; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = x;
        acc = 768 * longint'(mh[0] + mh[5]) - 4096 * longint'(mh[1] + mh[4])
            + 19712 * longint'(mh[2] + mh[3]);
        r = (acc + 16384) >>> 15;
`ifdef HB_INTERP_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`else
        r = ((r + 32768) & 64'd65535) - 32768;
`endif
        exp_q.push_back(int'(r));
        exp_q.push_back(mh[2]);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_data_out"}, int'(bus.data_out), 0);
        check({tag, "_stb_out"}, int'(bus.stb_out), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_fifo_level"}, int'(bus.fifo_level), 0);
        check({tag, "_overflow"}, int'(bus.overflow), 0);
        check({tag, "_underflow"}, int'(bus.underflow), 0);
    endtask

    task automatic do_reset();
        check("drained_before_reset", exp_q.size(), 0);
        bus.stb_in = 1'b0;
        bus.req    = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        got_log.delete();
    endtask

    // Sample at cycle T, optional colliding strobe at T+3, optional pops at T+6 and T+7.
    task automatic send_sample(input int x, input bit extra, input bit pop, input bit acc, input bit chk);
        bus.data_in = 16'(x);
        bus.stb_in  = 1'b1;
        if (acc) model_push(x);
        tick();
        bus.stb_in = 1'b0;
        if (chk) check("busy_at_t1", int'(bus.busy), 1);
        tick();
        tick();
        if (extra) begin
            bus.data_in = 16'($urandom);
            bus.stb_in  = 1'b1;
        end
        tick();
        bus.stb_in = 1'b0;
        tick();
        tick();
        if (chk) begin
            check("fifo_level_at_t6", int'(bus.fifo_level), 2);
            check("idle_at_t6", int'(bus.busy), 0);
        end
        if (pop) begin
            bus.req = 1'b1;
            tick();
            if (chk) check("stb_out_at_t7", int'(bus.stb_out), 1);
            tick();
            bus.req = 1'b0;
        end else begin
            tick();
            tick();
        end
    endtask

    always @(negedge clk) begin
        int got;
        int e;
        if (bus.stb_out) begin
            got = int'(bus.data_out);
            got_log.push_back(got);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_stb_out: got data_out=%0d, expected no output", got);
            end else begin
                e = exp_q.pop_front();
                $display("out %0d: data_out=%0d expected=%0d", n_out, got, e);
                check("data_out", got, e);
            end
            n_out++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation ran past its time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int imp_exp[16] = '{384, 0, -2048, 0, 9856, 16384, 9856, 0, -2048, 0, 384, 0, 0, 0, 0, 0};
        int x;
        bus.enable  = 1'b1;
        bus.data_in = '0;
        bus.stb_in  = 1'b0;
        bus.req     = 1'b0;
        model_clear();
        do_reset();
        check_cleared("reset");

        // Underflow on an empty FIFO, then single-sample timing
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        check("underflow_set", int'(bus.underflow), 1);
        check("no_stb_on_empty", int'(bus.stb_out), 0);
        send_sample(12000, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();

        // Impulse response
        do_reset();
        send_sample(16384, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send_sample(0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check("impulse_len", got_log.size(), 16);
        for (int i = 0; i < 16 && i < got_log.size(); i++) check("impulse_tap", got_log[i], imp_exp[i]);

        // DC gain
        do_reset();
        for (int i = 0; i < 12; i++) send_sample(1000, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check("dc_len", got_log.size(), 24);
        for (int i = 10; i < 24 && i < got_log.size(); i++) check("dc_steady", got_log[i], 1000);

        // Abort mid-MAC: data_out and sticky flags non-zero beforehand
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        check("dc_hold", int'(bus.data_out), 1000);
        bus.data_in = 16'(7777);
        bus.stb_in  = 1'b1;
        model_push(7777);
        tick();
        bus.stb_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_cleared("mid_mac_reset");
        rst = 1'b0;
        model_clear();
        repeat (10) tick();
        check("no_push_after_abort", int'(bus.fifo_level), 0);
        check("idle_after_abort", int'(bus.busy), 0);

        // Saturation / wrap excitation
        do_reset();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 3; i++)
                send_sample((b % 2 == 0) ? 32767 : -32768, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_sample(0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();

        // Collision while busy: second strobe dropped
        do_reset();
        send_sample(20000, 1'b1, 1'b1, 1'b1, 1'b1);
        check("overflow_on_busy", int'(bus.overflow), 1);
        tick();

        // FIFO fill boundary: accept at level 2, drop at level 4
        do_reset();
        send_sample(-15000, 1'b0, 1'b0, 1'b1, 1'b1);
        send_sample(25000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("no_overflow_at_level2", int'(bus.overflow), 0);
        check("fifo_full", int'(bus.fifo_level), 4);
        send_sample(3333, 1'b0, 1'b0, 1'b0, 1'b0);
        check("overflow_at_level4", int'(bus.overflow), 1);
        check("fifo_still_full", int'(bus.fifo_level), 4);
        bus.req = 1'b1;
        repeat (4) tick();
        bus.req = 1'b0;
        tick();
        check("fifo_drained", int'(bus.fifo_level), 0);
        check("no_underflow_while_draining", int'(bus.underflow), 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) x = ($urandom_range(0, 1) == 0) ? 32767 : -32768;
            else x = int'($urandom_range(0, 65535)) - 32768;
            send_sample(x, ($urandom_range(0, 3) == 0), 1'b1, 1'b1, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        tick();

        // enable low clears like reset
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        check("underflow_before_disable", int'(bus.underflow), 1);
        bus.enable = 1'b0;
        tick();
        check_cleared("enable_low");
        bus.enable = 1'b1;
        model_clear();
        repeat (4) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
